// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encodings and port ids for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_OWN0  = 2'd1;
    localparam logic [1:0] ARB_OWN1  = 2'd2;
    localparam logic [1:0] ARB_DRAIN = 2'd3;
    localparam logic P_ICACHE = 1'b0;
    localparam logic P_DCACHE = 1'b1;
    function automatic logic [1:0] own_state(input logic port);
        return port == P_DCACHE ? ARB_OWN1 : ARB_OWN0;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// arb_rr_pick: round-robin choice between two requesters, ties go to the port that did not own last
module arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic any,
    output logic winner
);
    assign any    = req0 | req1;
    assign winner = (req0 & req1) ? ~rr_last : req1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants whole-transaction memory ownership to the I-cache or D-cache port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 32,
    parameter int CNT_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              rd0,
    input  logic              rd1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              grant0,
    output logic              grant1,
    output logic              stall0,
    output logic              stall1,
    output logic              preempt0,
    output logic              preempt1,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic [3:0]        busy,
    output logic              err
);
    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] hold_cnt;
    logic             rr_last, any, winner;
    logic             own0, own1, owning, o_req, o_rd, o_wr, mem_idle, at_max, enter;

    arb_rr_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last),
        .any     (any),
        .winner  (winner)
    );

    assign own0     = state == ARB_OWN0;
    assign own1     = state == ARB_OWN1;
    assign owning   = own0 | own1;
    assign o_req    = own1 ? req1 : req0;
    assign o_rd     = own1 ? rd1 : rd0;
    assign o_wr     = own1 ? wr1 : wr0;
    assign mem_idle = busy == '0;
    assign at_max   = hold_cnt == CNT_W'(MAX_HOLD);
    assign enter    = !owning && any && mem_idle;

    assign grant0    = own0;
    assign grant1    = own1;
    assign stall0    = own0 ? mem_stall : req0;
    assign stall1    = own1 ? mem_stall : req1;
    assign preempt0  = own0 & at_max & req1;
    assign preempt1  = own1 & at_max & req0;
    assign mem_rd    = owning & o_rd & ~o_wr;
    assign mem_wr    = owning & o_wr & ~o_rd;
    assign mem_addr  = own1 ? addr1 : addr0;
    assign mem_wdata = own1 ? wdata1 : wdata0;

    // IDLE and DRAIN behave alike: wait for quiet banks, then hand memory to the round-robin winner
    always_comb begin
        state_nx = owning ? (o_req ? state : ARB_DRAIN)
                 : !mem_idle ? state
                 : any ? own_state(winner) : ARB_IDLE;
    end

    // Owner state, fairness memory, saturating hold timer and sticky rd&wr error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            rr_last  <= P_ICACHE;
            hold_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            if (owning && !o_req) rr_last <= own1;
            if (enter) hold_cnt <= '0;
            else if (owning && !at_max) hold_cnt <= hold_cnt + 1'b1;
            if (owning && o_rd && o_wr) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and random run against an owner-level model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, rd0, rd1, wr0, wr1, mem_stall;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  busy;
    logic        grant0, grant1, stall0, stall1, preempt0, preempt1, mem_rd, mem_wr, err;
    logic [15:0] mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    int m_owner;
    int m_last;
    int m_held;
    bit m_err;

    typedef struct {
        logic r0, r1, rd0, wr0, rd1, wr1, ms;
        logic [3:0] bz;
        logic g0, g1, mrd, mwr, s0, s1;
    } vec_t;
    vec_t tbl[15];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .grant0(grant0), .grant1(grant1), .stall0(stall0), .stall1(stall1),
        .preempt0(preempt0), .preempt1(preempt1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0; mem_stall = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; busy = 0;
    endtask

    task automatic do_reset();
        tick();
        clear_inputs();
        rst = 0;
        #2;
        rst = 1;
    endtask

    task automatic model_step();
        logic rq[2], rdv[2], wrv[2];
        rq = '{req0, req1}; rdv = '{rd0, rd1}; wrv = '{wr0, wr1};
        if (m_owner >= 0) begin
            if (rdv[m_owner] && wrv[m_owner]) m_err = 1;
            if (!rq[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_held < 32) m_held++;
        end else if (busy == 0 && (rq[0] || rq[1])) begin
            m_owner = (rq[0] && rq[1]) ? 1 - m_last : (rq[1] ? 1 : 0);
            m_held  = 0;
        end
    endtask

    task automatic model_check();
        logic rq[2], rdv[2], wrv[2];
        logic [15:0] av[2];
        logic o_rd, o_wr;
        rq = '{req0, req1}; rdv = '{rd0, rd1}; wrv = '{wr0, wr1}; av = '{addr0, addr1};
        o_rd = m_owner >= 0 ? rdv[m_owner] : 1'b0;
        o_wr = m_owner >= 0 ? wrv[m_owner] : 1'b0;
        chk("rnd_grant0", grant0, m_owner == 0);
        chk("rnd_grant1", grant1, m_owner == 1);
        chk("rnd_stall0", stall0, m_owner == 0 ? mem_stall : rq[0]);
        chk("rnd_stall1", stall1, m_owner == 1 ? mem_stall : rq[1]);
        chk("rnd_preempt0", preempt0, m_owner == 0 && m_held == 32 && rq[1]);
        chk("rnd_preempt1", preempt1, m_owner == 1 && m_held == 32 && rq[0]);
        chk("rnd_mem_rd", mem_rd, o_rd && !o_wr);
        chk("rnd_mem_wr", mem_wr, o_wr && !o_rd);
        chk("rnd_err", err, m_err);
        if (m_owner >= 0) chk("rnd_mem_addr", mem_addr, av[m_owner]);
    endtask

    initial begin
        int o;
        rst = 0;
        clear_inputs();
        tbl[0]  = '{0,1,0,0,1,0,0,4'h0, 0,0,0,0,0,1};
        tbl[1]  = '{0,1,0,0,1,0,0,4'h0, 0,1,1,0,0,0};
        tbl[2]  = '{1,1,0,0,1,0,1,4'h0, 0,1,1,0,1,1};
        tbl[3]  = '{1,0,0,0,0,0,0,4'h0, 0,1,0,0,1,0};
        tbl[4]  = '{1,0,1,0,0,0,0,4'h4, 0,0,0,0,1,0};
        tbl[5]  = '{1,0,1,0,0,0,0,4'h4, 0,0,0,0,1,0};
        tbl[6]  = '{1,0,1,0,0,0,0,4'h4, 0,0,0,0,1,0};
        tbl[7]  = '{1,0,1,0,0,0,0,4'h0, 0,0,0,0,1,0};
        tbl[8]  = '{1,0,1,0,0,0,1,4'h0, 1,0,1,0,1,0};
        tbl[9]  = '{1,0,0,1,0,0,0,4'h0, 1,0,0,1,0,0};
        tbl[10] = '{0,0,0,0,0,0,0,4'h0, 1,0,0,0,0,0};
        tbl[11] = '{0,0,0,0,0,0,0,4'h0, 0,0,0,0,0,0};
        tbl[12] = '{0,1,0,0,0,1,0,4'h1, 0,0,0,0,0,1};
        tbl[13] = '{0,1,0,0,0,1,0,4'h0, 0,0,0,0,0,1};
        tbl[14] = '{0,1,0,0,0,1,0,4'h0, 0,1,0,1,0,0};

        do_reset();
        chk("reset_grant0", grant0, 0);
        chk("reset_grant1", grant1, 0);
        chk("reset_err", err, 0);
        chk("reset_preempt0", preempt0, 0);
        for (int i = 0; i < 15; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; rd0 = tbl[i].rd0; wr0 = tbl[i].wr0;
            rd1 = tbl[i].rd1; wr1 = tbl[i].wr1; mem_stall = tbl[i].ms; busy = tbl[i].bz;
            #1;
            chk($sformatf("tbl%0d_grant0", i), grant0, tbl[i].g0);
            chk($sformatf("tbl%0d_grant1", i), grant1, tbl[i].g1);
            chk($sformatf("tbl%0d_mem_rd", i), mem_rd, tbl[i].mrd);
            chk($sformatf("tbl%0d_mem_wr", i), mem_wr, tbl[i].mwr);
            chk($sformatf("tbl%0d_stall0", i), stall0, tbl[i].s0);
            chk($sformatf("tbl%0d_stall1", i), stall1, tbl[i].s1);
            tick();
        end

        do_reset();
        req1 = 1; rd1 = 1; wr1 = 1;
        tick();
        tick();
        wr1 = 0;
        #1;
        chk("async_pre_grant1", grant1, 1);
        chk("async_pre_mem_rd", mem_rd, 1);
        chk("async_pre_err", err, 1);
        rst = 0;
        #1;
        chk("async_grant1", grant1, 0);
        chk("async_grant0", grant0, 0);
        chk("async_mem_rd", mem_rd, 0);
        chk("async_mem_wr", mem_wr, 0);
        chk("async_err", err, 0);
        rst = 1;

        do_reset();
        req1 = 1; rd1 = 1; addr1 = 16'h0040;
        #1;
        chk("fill_grant_before_edge", grant1, 0);
        tick();
        chk("fill_grant_edge1", grant1, 1);
        for (int i = 0; i < 7; i++) begin
            addr1 = 16'h0040 + 16'(i);
            #1;
            chk($sformatf("fill_addr%0d", i), mem_addr, 16'h0040 + 16'(i));
            chk($sformatf("fill_rd%0d", i), mem_rd, 1);
            tick();
        end
        req1 = 0; rd1 = 0;
        #1;
        chk("fill_drop_still_granted", grant1, 1);
        tick();
        chk("fill_drain_grant1", grant1, 0);
        tick();
        chk("fill_idle_grant1", grant1, 0);
        chk("fill_idle_grant0", grant0, 0);

        do_reset();
        req0 = 1; req1 = 1;
        tick();
        chk("alt_first_grant1", grant1, 1);
        chk("alt_first_grant0", grant0, 0);
        o = 1;
        for (int t = 0; t < 4; t++) begin
            tick();
            tick();
            chk($sformatf("alt%0d_hold", t), {grant1, grant0}, o == 1 ? 2'b10 : 2'b01);
            if (o == 1) req1 = 0; else req0 = 0;
            tick();
            chk($sformatf("alt%0d_drain", t), {grant1, grant0}, 2'b00);
            if (o == 1) req1 = 1; else req0 = 1;
            tick();
            o = 1 - o;
            chk($sformatf("alt%0d_switch", t), {grant1, grant0}, o == 1 ? 2'b10 : 2'b01);
        end

        do_reset();
        req0 = 1; rd0 = 1;
        tick();
        req1 = 1;
        for (int k = 0; k < 40; k++) begin
            #1;
            chk($sformatf("hold%0d_preempt0", k), preempt0, k >= 32);
            chk($sformatf("hold%0d_grant0", k), grant0, 1);
            if (k == 20 || k == 39) chk($sformatf("hold%0d_preempt1", k), preempt1, 0);
            @(posedge clk);
        end
        #1;
        req0 = 0;
        tick();
        chk("hold_release_grant0", grant0, 0);
        chk("hold_release_preempt0", preempt0, 0);
        tick();
        chk("hold_release_grant1", grant1, 1);

        do_reset();
        req0 = 1; rd0 = 1;
        tick();
        wr0 = 1;
        #1;
        chk("rdwr_mem_rd", mem_rd, 0);
        chk("rdwr_mem_wr", mem_wr, 0);
        chk("rdwr_err_same_cycle", err, 0);
        tick();
        chk("rdwr_err_next", err, 1);
        req0 = 0; rd0 = 0; wr0 = 0;
        tick();
        tick();
        tick();
        chk("rdwr_err_sticky", err, 1);

        do_reset();
        m_owner = -1; m_last = 0; m_held = 0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) req0 = ~req0;
            if ($urandom_range(0, 39) == 0) req1 = ~req1;
            rd0 = 1'($urandom);
            rd1 = 1'($urandom);
            wr0 = rd0 ? ($urandom_range(0, 199) == 0) : 1'($urandom);
            wr1 = rd1 ? ($urandom_range(0, 199) == 0) : 1'($urandom);
            busy = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            mem_stall = 1'($urandom);
            addr0 = 16'($urandom); addr1 = 16'($urandom);
            wdata0 = 16'($urandom); wdata1 = 16'($urandom);
            #1;
            model_check();
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
